// File: rtl/seg7_display_arbiter.sv
// rtl/seg7_display_arbiter.sv - shares the 8-digit display between three round-robin sources and a pre-empting alert
module seg7_display_arbiter #(
  parameter int CLK_PER_MS = 100_000,
  parameter int DWELL_MS   = 2000,
  parameter int GAP_MS     = 100,
  parameter int ALERT_MS   = 500
) (
  input  logic        clk100mhz,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [31:0] ch0_data,
  input  logic [31:0] ch1_data,
  input  logic [31:0] ch2_data,
  input  logic        alert_req,
  input  logic [31:0] alert_data,
  output logic [31:0] disp_data,
  output logic        disp_blank,
  output logic [3:0]  grant,
  output logic        alert_ack
);

  localparam int MAX_MS = (DWELL_MS > GAP_MS) ?
                          ((DWELL_MS > ALERT_MS) ? DWELL_MS : ALERT_MS) :
                          ((GAP_MS > ALERT_MS) ? GAP_MS : ALERT_MS);
  localparam int PW = $clog2(CLK_PER_MS + 1);
  localparam int MW = $clog2(MAX_MS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [MW-1:0] DWELL_LAST = MW'(DWELL_MS - 1);
  localparam logic [MW-1:0] GAP_LAST   = MW'(GAP_MS - 1);
  localparam logic [MW-1:0] ALERT_LAST = MW'(ALERT_MS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP, ST_ALERT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]      cur_q, cur_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [MW-1:0]   ms_q, ms_d;
  logic            alert_pending_q, alert_pending_d;
  logic [31:0]     alert_word_q, alert_word_d;
  logic [31:0]     disp_data_q, disp_data_d;
  logic            disp_blank_q, disp_blank_d;
  logic [3:0]      grant_q, grant_d;
  logic            alert_ack_q, alert_ack_d;

  logic            tick;
  logic            expire;
  logic            restart;
  logic [MW-1:0]   dur_last;
  logic [2:0]      cur_oh;
  logic [31:0]     ch_sel;

  // Round-robin search order starts one past the last winner; caller guarantees r != 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
    logic [1:0] a, b, c;
    case (ptr)
      2'd0:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
      2'd1:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
      default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
    endcase
    if (r[a])      rr_pick = a;
    else if (r[b]) rr_pick = b;
    else           rr_pick = c;
  endfunction

  function automatic logic [1:0] rr_before(input logic [1:0] ch);
    case (ch)
      2'd0:    rr_before = 2'd2;
      2'd1:    rr_before = 2'd0;
      default: rr_before = 2'd1;
    endcase
  endfunction

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    cur_d           = cur_q;
    alert_pending_d = alert_pending_q | alert_req;
    alert_word_d    = alert_req ? alert_data : alert_word_q;
    alert_ack_d     = 1'b0;
    restart         = 1'b0;
    cur_oh          = 3'b001 << cur_q;

    case (state_q)
      ST_SHOW: dur_last = DWELL_LAST;
      ST_GAP:  dur_last = GAP_LAST;
      default: dur_last = ALERT_LAST;
    endcase
    tick   = (presc_q == PRESC_LAST);
    expire = tick && (ms_q == dur_last);

    if (alert_req || alert_pending_q) begin
      state_d = ST_ALERT;
      restart = 1'b1;
      if (state_q == ST_SHOW) rr_ptr_d = rr_before(cur_q);
    end else begin
      case (state_q)
        ST_IDLE: begin
          restart = 1'b1;
          if (|req) begin
            state_d  = ST_SHOW;
            cur_d    = rr_pick(req, rr_ptr_q);
            rr_ptr_d = cur_d;
          end
        end
        ST_SHOW: begin
          if (!req[cur_q]) begin
            state_d = (|req) ? ST_GAP : ST_IDLE;
          end else if (expire) begin
            if (|(req & ~cur_oh)) state_d = ST_GAP;
            else                  restart = 1'b1;
          end
        end
        default: begin
          // GAP and ALERT both arbitrate straight into SHOW on expiry.
          if (expire) begin
            alert_ack_d = (state_q == ST_ALERT);
            if (|req) begin
              state_d  = ST_SHOW;
              cur_d    = rr_pick(req, rr_ptr_q);
              rr_ptr_d = cur_d;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      endcase
    end

    if (state_d != state_q) restart = 1'b1;
    if (state_d == ST_ALERT) alert_pending_d = 1'b0;

    if (restart) begin
      presc_d = '0;
      ms_d    = '0;
    end else if (tick) begin
      presc_d = '0;
      ms_d    = ms_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
      ms_d    = ms_q;
    end

    case (cur_d)
      2'd0:    ch_sel = ch0_data;
      2'd1:    ch_sel = ch1_data;
      default: ch_sel = ch2_data;
    endcase

    case (state_d)
      ST_SHOW: begin
        disp_data_d  = ch_sel;
        disp_blank_d = 1'b0;
        grant_d      = {1'b0, 3'b001 << cur_d};
      end
      ST_ALERT: begin
        disp_data_d  = alert_word_d;
        disp_blank_d = 1'b0;
        grant_d      = 4'b1000;
      end
      default: begin
        disp_data_d  = '0;
        disp_blank_d = 1'b1;
        grant_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk100mhz) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      rr_ptr_q        <= 2'd2;
      cur_q           <= 2'd0;
      presc_q         <= '0;
      ms_q            <= '0;
      alert_pending_q <= 1'b0;
      alert_word_q    <= '0;
      disp_data_q     <= '0;
      disp_blank_q    <= 1'b1;
      grant_q         <= '0;
      alert_ack_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      cur_q           <= cur_d;
      presc_q         <= presc_d;
      ms_q            <= ms_d;
      alert_pending_q <= alert_pending_d;
      alert_word_q    <= alert_word_d;
      disp_data_q     <= disp_data_d;
      disp_blank_q    <= disp_blank_d;
      grant_q         <= grant_d;
      alert_ack_q     <= alert_ack_d;
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_blank = disp_blank_q;
  assign grant      = grant_q;
  assign alert_ack  = alert_ack_q;

endmodule
